// File: rtl/fp_cmp_stage_if.sv
// Compare-unit bundle: pipeline controls, Compare_in operands and writeback packet.
interface fp_cmp_stage_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int REG_AW = 5
);
    logic              stall;
    logic              bubble;
    logic [OP_W-1:0]   cmp_op;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic [REG_AW-1:0] cmp_dst;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic              busy;

    modport master (
        output stall, bubble, cmp_op, cmp_a, cmp_b, cmp_dst,
        input  wb_valid, wb_dst, wb_data, busy
    );

    modport slave (
        input  stall, bubble, cmp_op, cmp_a, cmp_b, cmp_dst,
        output wb_valid, wb_dst, wb_data, busy
    );
endinterface

// File: rtl/fp_cmp_stage.sv
// Two-stage Float32 compare / unordered / min / max unit with stall and bubble controls.
// Define FP_CMP_FLAGS_EN to add the sticky invalid-operation flag (flag_clr, invalid_flag).
module fp_cmp_stage #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int REG_AW = 5
) (
    input  logic clk,
    input  logic rst,
`ifdef FP_CMP_FLAGS_EN
    input  logic flag_clr,
    output logic invalid_flag,
`endif
    fp_cmp_stage_if.slave bus
);

    localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_EQ  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LT  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LE  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_UN  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MIN = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MAX = OP_W'(6);
    localparam logic [DATA_W-1:0] CANON_NAN = DATA_W'(32'h7FC0_0000);

    function automatic logic is_nan(input logic [DATA_W-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

`ifdef FP_CMP_FLAGS_EN
    function automatic logic is_snan(input logic [DATA_W-1:0] x);
        return is_nan(x) && !x[22];
    endfunction
`endif

    // Opcode 7 is reserved and behaves exactly like a NOP.
    function automatic logic [OP_W-1:0] legal_op(input logic [OP_W-1:0] op);
        return (op > OP_MAX) ? OP_NOP : op;
    endfunction

    logic              vld_p1;
    logic [OP_W-1:0]   op_p1;
    logic [REG_AW-1:0] dst_p1;
    logic [DATA_W-1:0] a_p1, b_p1;
    logic              nan_a_p1, nan_b_p1, both_zero_p1, mag_lt_p1, mag_eq_p1;

    logic              vld_p2;
    logic [REG_AW-1:0] dst_p2;
    logic [DATA_W-1:0] data_p2;

    logic              sign_a, sign_b, ordered_c, ord_lt_c, eq_c, lt_c;
    logic [DATA_W-1:0] min_c, max_c, res_c;

    // ---- S1: capture bundle, classify, magnitude compare ----
    always_ff @(posedge clk) begin
        if (!rst)
            vld_p1 <= 1'b0;
        else if (bus.bubble)
            vld_p1 <= 1'b0;
        else if (!bus.stall)
            vld_p1 <= (legal_op(bus.cmp_op) != OP_NOP);
    end

    always_ff @(posedge clk) begin
        if (!bus.bubble && !bus.stall) begin
            op_p1        <= legal_op(bus.cmp_op);
            dst_p1       <= bus.cmp_dst;
            a_p1         <= bus.cmp_a;
            b_p1         <= bus.cmp_b;
            nan_a_p1     <= is_nan(bus.cmp_a);
            nan_b_p1     <= is_nan(bus.cmp_b);
            both_zero_p1 <= ((bus.cmp_a | bus.cmp_b) & {1'b0, {(DATA_W-1){1'b1}}}) == '0;
            mag_lt_p1    <= bus.cmp_a[DATA_W-2:0] <  bus.cmp_b[DATA_W-2:0];
            mag_eq_p1    <= bus.cmp_a[DATA_W-2:0] == bus.cmp_b[DATA_W-2:0];
        end
    end

    // ---- S1 -> S2: result select ----
    always_comb begin
        sign_a    = a_p1[DATA_W-1];
        sign_b    = b_p1[DATA_W-1];
        ordered_c = !(nan_a_p1 || nan_b_p1);
        eq_c      = ordered_c && ((mag_eq_p1 && (sign_a == sign_b)) || both_zero_p1);
        // Negative operands reverse the magnitude order.
        if (sign_a != sign_b)
            ord_lt_c = sign_a;
        else if (sign_a)
            ord_lt_c = !mag_lt_p1 && !mag_eq_p1;
        else
            ord_lt_c = mag_lt_p1;
        lt_c = ordered_c && !both_zero_p1 && ord_lt_c;

        if (nan_a_p1 && nan_b_p1) begin
            min_c = CANON_NAN;
            max_c = CANON_NAN;
        end else if (nan_a_p1) begin
            min_c = b_p1;
            max_c = b_p1;
        end else if (nan_b_p1) begin
            min_c = a_p1;
            max_c = a_p1;
        end else if (both_zero_p1) begin
            min_c = {(sign_a | sign_b), {(DATA_W-1){1'b0}}};
            max_c = {(sign_a & sign_b), {(DATA_W-1){1'b0}}};
        end else begin
            min_c = lt_c ? a_p1 : b_p1;
            max_c = lt_c ? b_p1 : a_p1;
        end

        res_c = '0;
        case (op_p1)
            OP_EQ:   res_c = DATA_W'(eq_c);
            OP_LT:   res_c = DATA_W'(lt_c);
            OP_LE:   res_c = DATA_W'(lt_c || eq_c);
            OP_UN:   res_c = DATA_W'(!ordered_c);
            OP_MIN:  res_c = min_c;
            OP_MAX:  res_c = max_c;
            default: res_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            vld_p2 <= 1'b0;
        else if (!bus.stall)
            vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        if (!bus.stall) begin
            dst_p2  <= dst_p1;
            data_p2 <= res_c;
        end
    end

`ifdef FP_CMP_FLAGS_EN
    logic snan_a_p1, snan_b_p1, inv_c, inv_p2, invalid_q;

    always_ff @(posedge clk) begin
        if (!bus.bubble && !bus.stall) begin
            snan_a_p1 <= is_snan(bus.cmp_a);
            snan_b_p1 <= is_snan(bus.cmp_b);
        end
    end

    always_comb begin
        inv_c = 1'b0;
        case (op_p1)
            OP_LT, OP_LE:                  inv_c = nan_a_p1 || nan_b_p1;
            OP_EQ, OP_UN, OP_MIN, OP_MAX:  inv_c = snan_a_p1 || snan_b_p1;
            default:                       inv_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!bus.stall)
            inv_p2 <= inv_c;
    end

    // Flag is raised when the op retires from S2; a clear wins over a same-edge set.
    always_ff @(posedge clk) begin
        if (!rst)
            invalid_q <= 1'b0;
        else if (flag_clr)
            invalid_q <= 1'b0;
        else if (!bus.stall && vld_p2 && inv_p2)
            invalid_q <= 1'b1;
    end

    assign invalid_flag = invalid_q;
`endif

    // ---- S2: writeback packet ----
    assign bus.wb_valid = vld_p2;
    assign bus.wb_dst   = vld_p2 ? dst_p2  : '0;
    assign bus.wb_data  = vld_p2 ? data_p2 : '0;
    assign bus.busy     = vld_p1 || vld_p2;

endmodule

// File: doc/fp_cmp_stage.md
Name: fp_cmp_stage

Overview:
- Execute-side floating-point compare unit; consumes the Compare_in bundle (op, a, b, dst) registered by the decode/execute pipeline register.
- 2-stage pipeline: S1 classifies and magnitude-compares, S2 selects the result and presents a writeback packet to the memory/writeback path.
- Obeys the same stall/bubble pipeline controls as the surrounding stages.
- Implements IEEE-754 single-precision compare, unordered test, and min/max.

Parameters:
- DATA_W, 32, operand/result width; Float32 only, other values unsupported.
- OP_W, 3, compare opcode width.
- REG_AW, 5, destination register address width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- stall  input  1  hold both pipeline stages.
- bubble  input  1  load NOP into S1 instead of the input bundle.
- cmp_op  input  OP_W  0=NOP 1=EQ 2=LT 3=LE 4=UN 5=MIN 6=MAX 7=reserved (treated as NOP).
- cmp_a  input  DATA_W  operand a (Float32 bits).
- cmp_b  input  DATA_W  operand b (Float32 bits).
- cmp_dst  input  REG_AW  destination FP register address.
- wb_valid  output  1  S2 holds a non-NOP result.
- wb_dst  output  REG_AW  destination address of the S2 result.
- wb_data  output  DATA_W  result: 0/1 for EQ/LT/LE/UN; Float32 value for MIN/MAX.
- busy  output  1  S1 or S2 holds a non-NOP op; used by the hazard unit.

Behaviour:
- Reset (rst==0 at posedge): S1 and S2 cleared to NOP. wb_valid=0, wb_dst=0, wb_data=0, busy=0. Reset overrides stall and bubble. Ops in flight are discarded.
- Latency: a bundle accepted at edge N (stall=0, bubble=0) appears on wb_* after edge N+1. Throughput is 1 op/cycle.
- S1 register contents: op, dst, a, b, plus flags.
  - nan_a, nan_b: exponent==0xFF and mantissa!=0.
  - snan_a, snan_b: NaN with mantissa bit22==0.
  - both_zero: (a|b)[30:0]==0.
  - mag_lt, mag_eq: unsigned compare of bits[30:0].
- S2 computes wb_data from S1 flags. "Ordered" means neither operand is NaN.
  - EQ: ordered and (bits equal or both_zero).
  - LT: ordered and not both_zero and signed order a<b, derived from signs and mag_lt (negatives reverse magnitude order).
  - LE: LT or EQ.
  - UN: nan_a or nan_b.
  - MIN/MAX with one NaN: return the other operand.
  - MIN/MAX with both NaN: return canonical 0x7FC00000.
  - MIN/MAX with -0 vs +0: MIN returns 0x80000000, MAX returns 0x00000000.
  - MIN/MAX otherwise: return the lesser or greater operand bit-exact.
  - NOP and reserved opcodes: wb_valid=0, wb_data=0, wb_dst=0.
- Stage-advance priority, per edge: rst > bubble (S1 only) > stall > advance.
  - stall=1, bubble=0: S1 and S2 both hold; inputs ignored.
  - bubble=1, stall=0: S1 loads NOP; old S1 advances to S2.
  - bubble=1, stall=1: S1 loads NOP (its old op is flushed); S2 holds.
- busy is combinational from S1.op!=NOP or S2.op!=NOP.
- No flags, exceptions, or rounding apply; results are exact.

Optional Feature:
- Macro: FP_CMP_FLAGS_EN.
- Enabled: adds two ports.
  - flag_clr  input  1: clears the sticky flag.
  - invalid_flag  output  1: sticky IEEE invalid-operation flag.
- Invalid-flag set conditions, evaluated when an op leaves S2 (S2 advances, stall=0, S2 op not NOP):
  - LT or LE with any NaN operand.
  - EQ, UN, MIN or MAX with any sNaN operand.
- Flag priority: reset clears to 0; flag_clr beats a same-cycle set.
- Disabled: neither port exists and no flag logic is built; all other behaviour is identical.

Test Plan:
- Reset then EQ a=0x3F800000 b=0x3F800000 dst=3 -> two edges later wb_valid=1, wb_dst=3, wb_data=1; busy=0 after it drains.
- Back-to-back LT(0xBF800000,0x3F800000), LT(0x40000000,0x3F800000), LE(0x80000000,0x00000000) -> wb_data 1, 0, 1 on consecutive cycles.
- MIN(0x00000000,0x80000000) -> 0x80000000; MAX(0x7FC00000,0x40000000) -> 0x40000000; MIN(0x7FC00000,0x7F800001) -> 0x7FC00000; UN(0x7F800001,0x3F800000) -> 1.
- Issue EQ, then hold stall=1 for 3 cycles with new inputs applied -> wb_* frozen; no new op captured; resumes exactly once.
- stall=1 and bubble=1 together with LT in S1 -> that LT never reaches wb; S2 op held; next cycle wb shows the held op, then NOP.
- FP_CMP_FLAGS_EN: LT(0x7FC00000,0x3F800000) -> invalid_flag=1 and stays 1; flag_clr pulse -> 0; EQ with qNaN -> flag stays 0; rst=0 mid-op -> all outputs 0 next edge.
